// File: rtl/dc_token_ring_writer.sv
// Writer end of the token-ring dual-clock channel: slot array, one-hot write token, read-pointer synchronizer.
// Optional `DC_WRITER_SYNC3_EN selects a 3-stage read-pointer synchronizer (default 2 stages).
module dc_token_ring_writer #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic [DATA_WIDTH-1:0]              data_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  output logic [BUFFER_DEPTH-1:0]            write_token_o,
  input  logic [BUFFER_DEPTH-1:0]            read_pointer_i,
  output logic [BUFFER_DEPTH*DATA_WIDTH-1:0] data_async_o,
  output logic                               empty_o
);

`ifdef DC_WRITER_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

  logic [BUFFER_DEPTH-1:0]                  wt_q, wt_d, wt_rot;
  logic [SYNC_STAGES-1:0][BUFFER_DEPTH-1:0] rp_sync_q;
  logic [BUFFER_DEPTH-1:0]                  rp_last;
  logic [BUFFER_DEPTH-1:0][DATA_WIDTH-1:0]  data_q;
  logic                                     full, write;

  assign wt_rot  = {wt_q[BUFFER_DEPTH-2:0], wt_q[BUFFER_DEPTH-1]};
  assign rp_last = rp_sync_q[SYNC_STAGES-1];

  // Conservative for 2-hot (may falsely report full) and 0-hot (old slot already consumed).
  assign full  = |(wt_rot & rp_last);
  assign write = valid_i && !full;

  always_comb begin
    wt_d = wt_q;
    if (write) wt_d = wt_rot;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wt_q <= BUFFER_DEPTH'(1);
      for (int s = 0; s < SYNC_STAGES; s++) rp_sync_q[s] <= BUFFER_DEPTH'(1);
      data_q <= '0;
    end else begin
      wt_q         <= wt_d;
      rp_sync_q[0] <= read_pointer_i;
      for (int s = 1; s < SYNC_STAGES; s++) rp_sync_q[s] <= rp_sync_q[s-1];
      if (write) begin
        for (int k = 0; k < BUFFER_DEPTH; k++) begin
          if (wt_q[k]) data_q[k] <= data_i;
        end
      end
    end
  end

  assign ready_o       = !full;
  assign write_token_o = wt_q;
  assign data_async_o  = data_q;
  assign empty_o       = (rp_last == wt_q);

endmodule

// File: tb/tb_dc_token_ring_writer.sv
// Self-checking bench for dc_token_ring_writer against an index-based reference model.
module tb_dc_token_ring_writer;
  localparam int DW = 32;
  localparam int D  = 8;
`ifdef DC_WRITER_SYNC3_EN
  localparam int NS = 3;
`else
  localparam int NS = 2;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          valid = 1'b0;
  logic [DW-1:0] data = '0;
  logic [D-1:0]  rp = 8'h01;
  logic          ready, empty;
  logic [D-1:0]  token;
  logic [D*DW-1:0] slots;

  dc_token_ring_writer #(.DATA_WIDTH(DW), .BUFFER_DEPTH(D)) dut (
    .clk_i(clk), .rstn_i(rstn), .data_i(data), .valid_i(valid), .ready_o(ready),
    .write_token_o(token), .read_pointer_i(rp), .data_async_o(slots), .empty_o(empty)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: write index, slot contents, history of driven read pointers.
  int          widx;
  logic [DW-1:0] mem [D];
  logic [D-1:0]  hist [NS];
  int          ridx;
  logic [DW-1:0] sb [$];

  function automatic logic m_ready();
    logic [D-1:0] nx;
    nx = 8'(1) << ((widx + 1) % D);
    return (nx & hist[NS-1]) == '0;
  endfunction

  function automatic logic [D*DW-1:0] m_flat();
    logic [D*DW-1:0] r;
    for (int k = 0; k < D; k++) r[k*DW +: DW] = mem[k];
    return r;
  endfunction

  task automatic check(input string tag, input logic [D*DW-1:0] obs, input logic [D*DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic acc;
    acc = rstn && valid && m_ready();
    @(posedge clk);
    if (!rstn) begin
      widx = 0;
      ridx = 0;
      sb.delete();
      for (int k = 0; k < D; k++) mem[k] = '0;
      for (int s = 0; s < NS; s++) hist[s] = 8'h01;
    end else begin
      if (acc) begin
        mem[widx] = data;
        sb.push_back(data);
        widx = (widx + 1) % D;
      end
      for (int s = NS - 1; s > 0; s--) hist[s] = hist[s-1];
      hist[0] = rp;
    end
    #1;
    check("token", token, 8'(1) << widx);
    check("ready", ready, m_ready());
    check("empty", empty, hist[NS-1] == (8'(1) << widx));
    check("slots", slots, m_flat());
  endtask

  task automatic rd_adv();
    if (sb.size() > 0) begin
      check("rd_data", slots[ridx*DW +: DW], sb.pop_front());
      ridx = (ridx + 1) % D;
      rp = 8'(1) << ridx;
    end
  endtask

  initial begin
    int lat, cnt, cyc, tstate;
    logic acc, hold;

    // Reset
    rstn = 1'b0; rp = 8'h01;
    step(); step();
    check("rst_token", token, 8'h01);
    check("rst_slots", slots, '0);
    rstn = 1'b1;

    // Fill 7 slots with the reader parked on slot 0
    for (int i = 0; i < D - 1; i++) begin
      valid = 1'b1; data = 32'hA0 + DW'(i);
      step();
    end
    valid = 1'b0;
    check("fill_ready", ready, 1'b0);
    check("fill_token", token, 8'h80);
    check("fill_empty", empty, 1'b0);
    check("fill_slot6", slots[6*DW +: DW], 32'hA6);

    // Backpressure
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1; data = 32'hDEAD;
      step();
    end
    valid = 1'b0;
    check("bp_token", token, 8'h80);

    // Release: reader consumes slot 0
    rd_adv();
    lat = 0;
    for (int i = 1; i <= NS + 2; i++) begin
      step();
      if (ready && lat == 0) lat = i;
    end
    check("release_lat", lat, NS);
    valid = 1'b1; data = 32'hB7;
    step();
    valid = 1'b0;
    check("wrap_token", token, 8'h01);
    check("wrap_slot7", slots[7*DW +: DW], 32'hB7);

    // Random streaming with 2-hot and 0-hot transients on the read pointer
    cnt = 0; cyc = 0; tstate = 0; hold = 1'b0;
    while (cnt < 20 && cyc < 400) begin
      valid = 1'($urandom_range(0, 3) != 0);
      data  = $urandom;
      acc   = valid && m_ready();
      step();
      if (acc) cnt++;
      cyc++;
      if (hold) begin
        rp = 8'(1) << ridx;
        hold = 1'b0;
      end else if (tstate == 0 && ridx == 1 && sb.size() > 0) begin
        rd_adv(); rp = 8'h06; hold = 1'b1; tstate = 1;
      end else if (tstate == 1 && sb.size() > 0) begin
        rd_adv(); rp = 8'h00; hold = 1'b1; tstate = 2;
      end else if (sb.size() > 0 && $urandom_range(0, 1) == 1) begin
        rd_adv();
      end
    end
    valid = 1'b0;
    check("stream_count", cnt, 20);
    check("transients_seen", tstate, 2);

    // Reset mid-stream
    rp = 8'h01; rstn = 1'b0;
    step();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1; data = 32'hC0 + DW'(i);
      step();
    end
    check("mid_token", token, 8'h08);
    valid = 1'b0; rstn = 1'b0;
    step();
    check("mid_rst_token", token, 8'h01);
    check("mid_rst_slots", slots, '0);
    rstn = 1'b1; valid = 1'b1; data = 32'hE5;
    step();
    valid = 1'b0;
    check("post_rst_slot0", slots[0 +: DW], 32'hE5);
    check("post_rst_token", token, 8'h02);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
